// File: rtl/miriscv_apb_pkg.sv
// Shared types for the core-to-APB3 bridge and the SoC peripheral decoders.
package miriscv_apb_pkg;

  localparam int PERIPH_REGION_BIT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/miriscv_apb_bridge.sv
// Core data bus to NSLV-slot APB3 bridge with wait states and PSLVERR reporting.
// Optional ACCESS-phase timeout is enabled by defining `MIRISCV_APB_TIMEOUT_EN.
module miriscv_apb_bridge
  import miriscv_apb_pkg::*;
#(
  parameter int NSLV        = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [DATA_W/8-1:0]    data_be_i,
  input  logic [ADDR_W-1:0]      data_addr_i,
  input  logic [DATA_W-1:0]      data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DATA_W-1:0]      data_rdata_o,
  output logic                   data_err_o,
  output logic [NSLV-1:0]        psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [ADDR_W-1:0]      paddr_o,
  output logic [DATA_W-1:0]      pwdata_o,
  output logic [DATA_W/8-1:0]    pstrb_o,
  input  logic [NSLV*DATA_W-1:0] prdata_i,
  input  logic [NSLV-1:0]        pready_i,
  input  logic [NSLV-1:0]        pslverr_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int PW    = (NSLV * DATA_W > 1) ? $clog2(NSLV * DATA_W) : 1;

  if (NSLV < 1 || NSLV > 16) begin : g_bad_nslv
    $error("miriscv_apb_bridge: NSLV must be 1..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("miriscv_apb_bridge: TIMEOUT_CYC must be >= 1");
  end

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  slot_q, slot_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;

  logic [IDX_W-1:0]  req_idx;
  logic              req_oob;
  logic              gnt;
  logic              timeout;
  logic [PW-1:0]     rd_base;
  logic [DATA_W-1:0] prdata_sel;

  if (NSLV > 1) begin : g_idx
    assign req_idx = data_addr_i[SEL_LSB +: IDX_W];
  end else begin : g_idx_single
    assign req_idx = '0;
  end

  assign req_oob    = int'(req_idx) >= NSLV;
  assign rd_base    = PW'(slot_q) * PW'(DATA_W);
  assign prdata_sel = prdata_i[rd_base +: DATA_W];
  assign gnt        = data_req_i & ((state_q == IDLE) | (state_q == RESP));

`ifdef MIRISCV_APB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == SETUP)       cnt_d = '0;
    else if (state_q == ACCESS) cnt_d = cnt_q + 1'b1;
  end

  // Fires in the TIMEOUT_CYC-th ACCESS cycle when the slot is still not ready.
  assign timeout = (state_q == ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    slot_d  = slot_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready_i[slot_q]) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : prdata_sel;
          err_d   = pslverr_i[slot_q];
        end else if (timeout) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (gnt) begin
      addr_d  = data_addr_i;
      wdata_d = data_wdata_i;
      be_d    = data_be_i;
      we_d    = data_we_i;
      slot_d  = req_idx;
      if (req_oob) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        state_d = SETUP;
      end
    end

    psel_d    = '0;
    if ((state_d == SETUP) || (state_d == ACCESS)) psel_d = NSLV'(1) << slot_d;
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      slot_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      we_q      <= we_d;
      slot_q    <= slot_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = (state_q == RESP);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = we_q;
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = be_q;

endmodule

// File: tb/tb_miriscv_apb_bridge.sv
// Directed bench for miriscv_apb_bridge; responses are checked against a scoreboard queue.
module tb_miriscv_apb_bridge;

  localparam int NSLV        = 3;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int SEL_LSB     = 12;
  localparam int TIMEOUT_CYC = 4;
  localparam int BE_W        = DATA_W / 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req, we;
  logic [BE_W-1:0]        be;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      wdata;
  logic                   gnt, rvalid, err;
  logic [DATA_W-1:0]      rdata;
  logic [NSLV-1:0]        psel;
  logic                   penable, pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [BE_W-1:0]        pstrb;
  logic [NSLV*DATA_W-1:0] prdata;
  logic [NSLV-1:0]        pready, pslverr;

  always #5 clk = ~clk;

  miriscv_apb_bridge #(
    .NSLV(NSLV), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .SEL_LSB(SEL_LSB), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk), .arst_i(rst),
    .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [DATA_W-1:0] d, input logic e);
    rsp_t r;
    r.rdata = d;
    r.err   = e;
    exp_q.push_back(r);
  endtask

  // Drive point is 1 time unit after the rising edge; checks follow #4 later (falling edge).
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] b);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = wd;
    be    = b;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) next_cyc();
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 64'(rvalid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rdata), 64'(e.rdata));
        chk("rsp_err", 64'(err), 64'(e.err));
      end
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    prdata = '0; pready = '0; pslverr = '0;

    #8;
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_rdata", 64'(rdata), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_psel", 64'(psel), 0);
    chk("rst_penable", 64'(penable), 0);
    chk("rst_pwrite", 64'(pwrite), 0);
    chk("rst_paddr", 64'(paddr), 0);
    chk("rst_pwdata", 64'(pwdata), 0);
    chk("rst_pstrb", 64'(pstrb), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: zero-wait read from slot 1
    prdata[1*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    pready = '1;
    next_cyc();
    drive_req(1'b0, 32'h8000_1004, 32'h0, 4'hF);
    #4;
    chk("t1_gnt", 64'(gnt), 1);
    chk("t1_psel_T", 64'(psel), 0);
    expect_rsp(32'hDEAD_BEEF, 1'b0);
    next_cyc();
    req = 1'b0;
    #4;
    chk("t1_setup_psel", 64'(psel), 64'b010);
    chk("t1_setup_penable", 64'(penable), 0);
    chk("t1_paddr", 64'(paddr), 64'h8000_1004);
    chk("t1_pwrite", 64'(pwrite), 0);
    chk("t1_setup_rvalid", 64'(rvalid), 0);
    next_cyc();
    #4;
    chk("t1_access_psel", 64'(psel), 64'b010);
    chk("t1_access_penable", 64'(penable), 1);
    next_cyc();
    #4;
    chk("t1_resp_rvalid", 64'(rvalid), 1);
    chk("t1_resp_psel", 64'(psel), 0);
    chk("t1_resp_penable", 64'(penable), 0);
    next_cyc();
    #4;
    chk("t1_idle_rvalid", 64'(rvalid), 0);
    chk("t1_rdata_hold", 64'(rdata), 64'hDEAD_BEEF);

    // 2: write to slot 0 with 3 wait states; other slots ready but must be ignored
    pready = 3'b110;
    next_cyc();
    drive_req(1'b1, 32'h8000_0010, 32'h55, 4'b0001);
    #4;
    chk("t2_gnt", 64'(gnt), 1);
    expect_rsp(32'h0, 1'b0);
    next_cyc();
    req = 1'b0; wdata = 32'hFFFF_FFFF; be = 4'hF;
    #4;
    chk("t2_setup_psel", 64'(psel), 64'b001);
    chk("t2_setup_penable", 64'(penable), 0);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      if (i == 3) pready[0] = 1'b1;
      #4;
      chk("t2_access_psel", 64'(psel), 64'b001);
      chk("t2_access_penable", 64'(penable), 1);
      chk("t2_pwdata", 64'(pwdata), 64'h55);
      chk("t2_pstrb", 64'(pstrb), 64'b0001);
      chk("t2_pwrite", 64'(pwrite), 1);
      chk("t2_access_rvalid", 64'(rvalid), 0);
    end
    next_cyc();
    #4;
    chk("t2_resp_rvalid", 64'(rvalid), 1);
    pready = '1;

    // 3: slot index 3 is out of range for NSLV=3
    next_cyc();
    drive_req(1'b0, 32'h8000_3000, 32'h0, 4'hF);
    #4;
    chk("t3_gnt", 64'(gnt), 1);
    expect_rsp(32'h0, 1'b1);
    next_cyc();
    req = 1'b0;
    #4;
    chk("t3_rvalid", 64'(rvalid), 1);
    chk("t3_psel", 64'(psel), 0);
    chk("t3_penable", 64'(penable), 0);

    // 4: PSLVERR on slot 0, then a back-to-back request granted in RESP
    prdata[0 +: DATA_W] = 32'h1234_5678;
    pslverr = 3'b001;
    next_cyc();
    drive_req(1'b0, 32'h8000_0020, 32'h0, 4'hF);
    #4;
    chk("t4_gnt", 64'(gnt), 1);
    expect_rsp(32'h1234_5678, 1'b1);
    next_cyc();
    req = 1'b0;
    #4;
    chk("t4_setup_psel", 64'(psel), 64'b001);
    next_cyc();
    #4;
    chk("t4_access_penable", 64'(penable), 1);
    next_cyc();
    pslverr = '0;
    prdata[1*DATA_W +: DATA_W] = 32'hCAFE_F00D;
    drive_req(1'b0, 32'h8000_1008, 32'h0, 4'hF);
    #4;
    chk("t4_resp_rvalid", 64'(rvalid), 1);
    chk("t4_resp_gnt", 64'(gnt), 1);
    expect_rsp(32'hCAFE_F00D, 1'b0);
    next_cyc();
    req = 1'b0;
    #4;
    chk("t4_b2b_psel", 64'(psel), 64'b010);
    chk("t4_b2b_penable", 64'(penable), 0);
    chk("t4_b2b_paddr", 64'(paddr), 64'h8000_1008);
    wait_drain(10);

    // 5: slot 0 never ready
    prdata[0 +: DATA_W] = 32'h0BAD_0BAD;
    pready = 3'b110;
    next_cyc();
    drive_req(1'b0, 32'h8000_0030, 32'h0, 4'hF);
    #4;
    chk("t5_gnt", 64'(gnt), 1);
`ifdef MIRISCV_APB_TIMEOUT_EN
    expect_rsp(32'h0, 1'b1);
`endif
    next_cyc();
    req = 1'b0;
    #4;
    chk("t5_setup_psel", 64'(psel), 64'b001);
`ifdef MIRISCV_APB_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      next_cyc();
      #4;
      chk("t5_access_psel", 64'(psel), 64'b001);
      chk("t5_access_penable", 64'(penable), 1);
      chk("t5_access_rvalid", 64'(rvalid), 0);
    end
    next_cyc();
    #4;
    chk("t5_to_rvalid", 64'(rvalid), 1);
    chk("t5_to_psel", 64'(psel), 0);
    chk("t5_to_penable", 64'(penable), 0);
`else
    for (int i = 0; i < 20; i++) begin
      next_cyc();
      #4;
      chk("t5_wait_psel", 64'(psel), 64'b001);
      chk("t5_wait_penable", 64'(penable), 1);
      chk("t5_wait_rvalid", 64'(rvalid), 0);
    end
    next_cyc();
    pready = '1;
    expect_rsp(32'h0BAD_0BAD, 1'b0);
    #4;
    chk("t5_last_penable", 64'(penable), 1);
    next_cyc();
    #4;
    chk("t5_rvalid", 64'(rvalid), 1);
`endif
    pready = '1;
    wait_drain(10);

    // 6: reset during ACCESS drops the bus and issues no response
    prdata[1*DATA_W +: DATA_W] = 32'h1111_2222;
    pready = 3'b101;
    next_cyc();
    drive_req(1'b0, 32'h8000_1000, 32'h0, 4'hF);
    #4;
    chk("t6_gnt", 64'(gnt), 1);
    next_cyc();
    req = 1'b0;
    next_cyc();
    #4;
    chk("t6_access_psel", 64'(psel), 64'b010);
    chk("t6_access_penable", 64'(penable), 1);
    next_cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst_psel", 64'(psel), 0);
    chk("t6_rst_penable", 64'(penable), 0);
    chk("t6_rst_rvalid", 64'(rvalid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      #4;
      chk("t6_post_rvalid", 64'(rvalid), 0);
      chk("t6_post_psel", 64'(psel), 0);
    end
    pready = '1;
    prdata[1*DATA_W +: DATA_W] = 32'hA5A5_0001;
    next_cyc();
    drive_req(1'b0, 32'h8000_1000, 32'h0, 4'hF);
    #4;
    chk("t6_next_gnt", 64'(gnt), 1);
    expect_rsp(32'hA5A5_0001, 1'b0);
    next_cyc();
    req = 1'b0;
    wait_drain(10);

    next_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

endmodule
